// File: rtl/guess_entry.sv
// Four-digit 1A2B guess entry: shifts keypad digits into h0..h3 and rejects illegal keys.
// A submitted guess is locked until the game FSM releases it or the player clears it.
module guess_entry #(
   parameter int MAX_DIGIT = 9,
   parameter bit ALLOW_DUP = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       key_del,
   input  logic       key_clr,
   input  logic       submit,
   input  logic       release_req,  // "release" is a reserved word
   output logic [3:0] h0,
   output logic [3:0] h1,
   output logic [3:0] h2,
   output logic [3:0] h3,
   output logic [2:0] count,
   output logic       disp_en,
   output logic       guess_vld,
   output logic       reject
);

   typedef enum logic [1:0] {EMPTY, ENTRY, FULL, LOCK} state_t;

   localparam logic [3:0] MAX_CODE = 4'(MAX_DIGIT);

   state_t     state_reg, state_next;
   logic [3:0] h_reg [4];
   logic [3:0] h_next [4];
   logic [2:0] count_reg, count_next;
   logic       guess_vld_reg, guess_vld_next;
   logic       reject_reg, reject_next;
   logic       disp_en_reg;
   logic [3:0] dup_hit;
   logic       digit_bad;

   // Only filled slots take part in the duplicate check, so an empty slot's 0 never blocks key 0.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_dup
         assign dup_hit[gi] = (h_reg[gi] == key_code) && (count_reg > 3'(gi));
      end
   endgenerate

   assign digit_bad = (key_code > MAX_CODE) || (!ALLOW_DUP && (|dup_hit));

   always_comb begin
      state_next     = state_reg;
      h_next         = h_reg;
      count_next     = count_reg;
      guess_vld_next = 1'b0;
      reject_next    = 1'b0;
      if (state_reg == LOCK) begin
         if (key_clr || release_req) begin
            for (int i = 0; i < 4; i++) h_next[i] = 4'd0;
            count_next = 3'd0;
            state_next = EMPTY;
         end
      end else if (key_clr) begin
         for (int i = 0; i < 4; i++) h_next[i] = 4'd0;
         count_next = 3'd0;
         state_next = EMPTY;
      end else if (key_del) begin
         if (count_reg != 3'd0) begin
            h_next[0]  = h_reg[1];
            h_next[1]  = h_reg[2];
            h_next[2]  = h_reg[3];
            h_next[3]  = 4'd0;
            count_next = count_reg - 3'd1;
            state_next = (count_reg == 3'd1) ? EMPTY : ENTRY;
         end
      end else if (submit) begin
         if (state_reg == FULL) begin
            state_next     = LOCK;
            guess_vld_next = 1'b1;
         end else begin
            reject_next = 1'b1;
         end
      end else if (key_valid) begin
         if ((state_reg == FULL) || digit_bad) begin
            reject_next = 1'b1;
         end else begin
            h_next[3]  = h_reg[2];
            h_next[2]  = h_reg[1];
            h_next[1]  = h_reg[0];
            h_next[0]  = key_code;
            count_next = count_reg + 3'd1;
            state_next = (count_reg == 3'd3) ? FULL : ENTRY;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= EMPTY;
         for (int i = 0; i < 4; i++) h_reg[i] <= 4'd0;
         count_reg     <= 3'd0;
         guess_vld_reg <= 1'b0;
         reject_reg    <= 1'b0;
         disp_en_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         h_reg         <= h_next;
         count_reg     <= count_next;
         guess_vld_reg <= guess_vld_next;
         reject_reg    <= reject_next;
         disp_en_reg   <= (count_next != 3'd0);
      end
   end

   assign h0        = h_reg[0];
   assign h1        = h_reg[1];
   assign h2        = h_reg[2];
   assign h3        = h_reg[3];
   assign count     = count_reg;
   assign disp_en   = disp_en_reg;
   assign guess_vld = guess_vld_reg;
   assign reject    = reject_reg;

endmodule
